uart_tx_frame_gen: RTL

UART_TX_FRAME_GEN -- requirements
Module: uart_tx_frame_gen

---
 rtl/uart_tx_frame_gen.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_tx_frame_gen.sv
// UART transmit frame generator: start bit, LSB-first data, optional parity,
// one or two stop bits, one serial bit per clock.
module uart_tx_frame_gen #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic                  par_bit,
    output logic                  FRAME_DONE
);

    localparam int            CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         bit_cnt_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  stop2_q;
    logic                  par_bit_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  par_bit_d;

    always_comb begin
        par_bit_d = 1'b0;
        case (PAR_TYP)
            2'b00:   par_bit_d = ^P_DATA;
            2'b01:   par_bit_d = ~^P_DATA;
            2'b10:   par_bit_d = 1'b1;
            default: par_bit_d = 1'b0;
        endcase
    end

    // Outputs are registered against the state being entered, so TX_OUT
    // shows the start bit in the first cycle after the acceptance edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (DATA_VALID) begin
                        state_q   <= S_START;
                        data_q    <= P_DATA;
                        par_en_q  <= PAR_EN;
                        stop2_q   <= STOP2;
                        par_bit_q <= par_bit_d;
                        tx_q      <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                S_START: begin
                    state_q   <= S_DATA;
                    bit_cnt_q <= '0;
                    tx_q      <= data_q[0];
                    data_q    <= data_q >> 1;
                end
                S_DATA: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (par_en_q) begin
                            state_q <= S_PARITY;
                            tx_q    <= par_bit_q;
                        end else begin
                            state_q <= S_STOP1;
                            tx_q    <= 1'b1;
                            done_q  <= ~stop2_q;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        tx_q      <= data_q[0];
                        data_q    <= data_q >> 1;
                    end
                end
                S_PARITY: begin
                    state_q <= S_STOP1;
                    tx_q    <= 1'b1;
                    done_q  <= ~stop2_q;
                end
                S_STOP1: begin
                    tx_q <= 1'b1;
                    if (stop2_q) begin
                        state_q <= S_STOP2;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_STOP2: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT     = tx_q;
    assign BUSY       = busy_q;
    assign par_bit    = par_bit_q;
    assign FRAME_DONE = done_q;

endmodule
